// File: rtl/mem_line_model.sv
// Line-granular backing memory for the cache-to-memory bus: whole-line reads and
// writes with a fixed response latency, burst transfer, protocol checks and counters.
//
// state        | meaning
// -------------+---------------------------------------------------------------
// S_IDLE       | waiting for a command; the only state that accepts one
// S_WR_COLLECT | capturing write beats 1..BEATS-1, line committed on the last
// S_WAIT       | latency down-counter running toward the response
// S_RD_SEND    | streaming read beats, lowest beat first
// S_WR_ACK     | single RESPONSE cycle acknowledging a committed write
module mem_line_model #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 16,
    parameter int LINE_BYTES = 16,
    parameter int LATENCY    = 100,
    // Counter width; a narrower build saturates early at 2^CNT_W-1.
    parameter int CNT_W      = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] a2_i,
    input  logic [1:0]        c2_i,
    input  logic [DATA_W-1:0] d2_i,
    output logic [1:0]        c2_o,
    output logic [DATA_W-1:0] d2_o,
    output logic              busy_o,
    output logic              proto_err_o,
    output logic [15:0]       rd_cnt_o,
    output logic [15:0]       wr_cnt_o
);

    localparam int LINE_W = LINE_BYTES * 8;
    localparam int BEATS  = LINE_W / DATA_W;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int BW     = $clog2(BEATS + 1);
    localparam int LW     = $clog2(LATENCY + 1);
    localparam int OW     = (LINE_W > 1) ? $clog2(LINE_W) : 1;

    localparam logic [BW-1:0]    LAST_BEAT = BW'(BEATS - 1);
    localparam logic [BW-1:0]    END_BEAT  = BW'(BEATS);
    localparam logic [LW-1:0]    LAT_LOAD  = LW'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    localparam logic [1:0] CMD_NOP  = 2'd0;
    localparam logic [1:0] CMD_RESP = 2'd1;
    localparam logic [1:0] CMD_RD   = 2'd2;
    localparam logic [1:0] CMD_WR   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_COLLECT,
        S_WAIT,
        S_RD_SEND,
        S_WR_ACK
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   addr;
    logic                is_wr;
    logic [LW-1:0]       lat_cnt;
    logic [BW-1:0]       beat;
    logic [LINE_W-1:0]   line_buf;
    logic [CNT_W-1:0]    rd_cnt;
    logic [CNT_W-1:0]    wr_cnt;

    logic [LINE_W-1:0]   mem [0:DEPTH-1];
    logic [LINE_W-1:0]   rd_line;
    logic [LINE_W-1:0]   wr_line;
    logic [ADDR_W-1:0]   mem_waddr;
    logic                mem_we;
    logic [OW-1:0]       wr_off;

    assign rd_line  = mem[addr];
    assign rd_cnt_o = 16'(rd_cnt);
    assign wr_cnt_o = 16'(wr_cnt);

    // Line being assembled this cycle; written to memory when the last beat lands.
    always_comb begin
        wr_line   = line_buf;
        mem_we    = 1'b0;
        mem_waddr = addr;
        wr_off    = OW'(beat * DATA_W);
        if (state == S_IDLE && c2_i == CMD_WR) begin
            wr_line              = '0;
            wr_line[DATA_W-1:0]  = d2_i;
            mem_we               = (BEATS == 1);
            mem_waddr            = a2_i;
        end else if (state == S_WR_COLLECT) begin
            wr_line[wr_off +: DATA_W] = d2_i;
            mem_we                    = (beat == LAST_BEAT);
        end
    end

    // Storage is deliberately outside the reset domain.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[mem_waddr] <= wr_line;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state       <= S_IDLE;
            addr        <= '0;
            is_wr       <= 1'b0;
            lat_cnt     <= '0;
            beat        <= '0;
            line_buf    <= '0;
            c2_o        <= CMD_NOP;
            d2_o        <= '0;
            busy_o      <= 1'b0;
            proto_err_o <= 1'b0;
            rd_cnt      <= '0;
            wr_cnt      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    case (c2_i)
                        CMD_RD: begin
                            addr    <= a2_i;
                            is_wr   <= 1'b0;
                            lat_cnt <= LAT_LOAD;
                            busy_o  <= 1'b1;
                            state   <= S_WAIT;
                        end
                        CMD_WR: begin
                            addr     <= a2_i;
                            is_wr    <= 1'b1;
                            line_buf <= wr_line;
                            beat     <= BW'(1);
                            busy_o   <= 1'b1;
                            if (BEATS == 1) begin
                                lat_cnt <= LAT_LOAD;
                                state   <= S_WAIT;
                            end else begin
                                state   <= S_WR_COLLECT;
                            end
                        end
                        CMD_RESP: proto_err_o <= 1'b1;
                        default: ;
                    endcase
                end
                S_WR_COLLECT: begin
                    line_buf <= wr_line;
                    if (c2_i != CMD_WR) begin
                        proto_err_o <= 1'b1;
                    end
                    if (beat == LAST_BEAT) begin
                        lat_cnt <= LAT_LOAD;
                        state   <= S_WAIT;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (c2_i != CMD_NOP) begin
                        proto_err_o <= 1'b1;
                    end
                    if (lat_cnt == '0) begin
                        c2_o <= CMD_RESP;
                        if (is_wr) begin
                            d2_o  <= '0;
                            state <= S_WR_ACK;
                        end else begin
                            d2_o     <= rd_line[DATA_W-1:0];
                            line_buf <= rd_line >> DATA_W;
                            beat     <= BW'(1);
                            state    <= S_RD_SEND;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                S_RD_SEND: begin
                    if (c2_i != CMD_NOP) begin
                        proto_err_o <= 1'b1;
                    end
                    if (beat == END_BEAT) begin
                        c2_o   <= CMD_NOP;
                        d2_o   <= '0;
                        busy_o <= 1'b0;
                        state  <= S_IDLE;
                        if (rd_cnt != CNT_MAX) begin
                            rd_cnt <= rd_cnt + 1'b1;
                        end
                    end else begin
                        d2_o     <= line_buf[DATA_W-1:0];
                        line_buf <= line_buf >> DATA_W;
                        beat     <= beat + 1'b1;
                    end
                end
                S_WR_ACK: begin
                    if (c2_i != CMD_NOP) begin
                        proto_err_o <= 1'b1;
                    end
                    c2_o   <= CMD_NOP;
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                    if (wr_cnt != CNT_MAX) begin
                        wr_cnt <= wr_cnt + 1'b1;
                    end
                end
                default: begin
                    c2_o   <= CMD_NOP;
                    d2_o   <= '0;
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_line_model.sv
// Scoreboard bench for mem_line_model: expected response beats are queued with their
// cycle stamp when a command is issued and popped by a monitor as RESPONSE beats appear.
module tb_mem_line_model;

    localparam int LAT = 4;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic [9:0]  a2_i = '0;
    logic [1:0]  c2_i = 2'd0;
    logic [15:0] d2_i = '0;

    logic [1:0]  c2_o, s_c2;
    logic [15:0] d2_o, s_d2;
    logic        busy_o, s_busy, proto_err_o, s_err;
    logic [15:0] rd_cnt_o, wr_cnt_o, s_rd, s_wr;

    mem_line_model #(.ADDR_W(10), .DATA_W(16), .LINE_BYTES(16), .LATENCY(LAT), .CNT_W(16)) u_dut (
        .CLK(CLK), .RESET(RESET), .a2_i(a2_i), .c2_i(c2_i), .d2_i(d2_i),
        .c2_o(c2_o), .d2_o(d2_o), .busy_o(busy_o), .proto_err_o(proto_err_o),
        .rd_cnt_o(rd_cnt_o), .wr_cnt_o(wr_cnt_o));

    // Narrow-counter build sharing the same stimulus; saturates at 3.
    mem_line_model #(.ADDR_W(10), .DATA_W(16), .LINE_BYTES(16), .LATENCY(LAT), .CNT_W(2)) u_sat (
        .CLK(CLK), .RESET(RESET), .a2_i(a2_i), .c2_i(c2_i), .d2_i(d2_i),
        .c2_o(s_c2), .d2_o(s_d2), .busy_o(s_busy), .proto_err_o(s_err),
        .rd_cnt_o(s_rd), .wr_cnt_o(s_wr));

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [31:0] cyc;
        logic [15:0] data;
    } exp_t;

    exp_t         sb[$];
    logic [127:0] model [int];
    logic [31:0]  cyc = '0;
    int           n_run = 0;
    int           n_fail = 0;
    int           exp_rd = 0;
    int           exp_wr = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every RESPONSE beat must match the head of the scoreboard in cycle and data.
    always @(negedge CLK) begin
        if (RESET) begin
            if (c2_o == 2'd1) begin
                if (sb.size() == 0) begin
                    n_run++; n_fail++;
                    $display("FAIL unexpected_resp: got d2=%0h at cycle %0d expected no response", d2_o, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("resp_cycle", cyc, e.cyc);
                    chk("resp_data", {16'h0, d2_o}, {16'h0, e.data});
                end
            end else if (c2_o != 2'd0) begin
                n_run++; n_fail++;
                $display("FAIL c2_o_code: got %0d expected 0 or 1", c2_o);
            end else if (sb.size() != 0 && sb[0].cyc < cyc) begin
                exp_t e;
                e = sb.pop_front();
                n_run++; n_fail++;
                $display("FAIL missing_resp: got NOP at cycle %0d expected data %0h at cycle %0d", cyc, e.data, e.cyc);
            end
        end
    end

    function automatic logic [127:0] mk_line(input logic [15:0] base, input logic [15:0] step);
        logic [127:0] ln;
        for (int i = 0; i < 8; i++) ln[i*16 +: 16] = base + step * 16'(i);
        return ln;
    endfunction

    task automatic do_reset();
        @(negedge CLK);
        c2_i = 2'd0;
        RESET = 1'b0;
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        exp_rd = 0;
        exp_wr = 0;
    endtask

    task automatic write_line(input logic [9:0] a, input logic [127:0] ln, input int drop);
        logic [31:0] t0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            c2_i = (i == drop) ? 2'd0 : 2'd3;
            a2_i = a;
            d2_i = ln[i*16 +: 16];
            if (i == 0) t0 = cyc + 1;
        end
        sb.push_back('{cyc: t0 + 7 + LAT, data: 16'h0});
        model[int'(a)] = ln;
        exp_wr++;
        @(negedge CLK);
        c2_i = 2'd0;
    endtask

    task automatic read_line(input logic [9:0] a);
        logic [31:0] t0;
        logic [127:0] ln;
        @(negedge CLK);
        c2_i = 2'd2;
        a2_i = a;
        t0 = cyc + 1;
        ln = model[int'(a)];
        for (int i = 0; i < 8; i++) sb.push_back('{cyc: t0 + LAT + i, data: ln[i*16 +: 16]});
        exp_rd++;
        @(negedge CLK);
        c2_i = 2'd0;
    endtask

    task automatic wait_idle(input string name);
        bit done = 0;
        for (int n = 0; n < 300 && !done; n++) begin
            @(negedge CLK);
            if (!busy_o && sb.size() == 0) done = 1;
        end
        if (!done) begin
            n_run++; n_fail++;
            $display("FAIL %s_timeout: got busy=%0d queued=%0d expected idle", name, busy_o, sb.size());
        end
        @(negedge CLK);
    endtask

    task automatic chk_cnt(input string name);
        chk({name, "_rd"}, {16'h0, rd_cnt_o}, exp_rd);
        chk({name, "_wr"}, {16'h0, wr_cnt_o}, exp_wr);
        chk({name, "_sat_rd"}, {16'h0, s_rd}, (exp_rd > 3) ? 3 : exp_rd);
        chk({name, "_sat_wr"}, {16'h0, s_wr}, (exp_wr > 3) ? 3 : exp_wr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        chk("rst_c2", {30'h0, c2_o}, 0);
        chk("rst_busy", {31'h0, busy_o}, 0);
        chk("rst_err", {31'h0, proto_err_o}, 0);
        chk("rst_rd", {16'h0, rd_cnt_o}, 0);
        repeat (2) @(negedge CLK);
        RESET = 1'b1;

        // 1/2: write then read back line 5
        write_line(10'h005, mk_line(16'h1111, 16'h1111), -1);
        wait_idle("t1");
        chk_cnt("t1");
        chk("t1_err", {31'h0, proto_err_o}, 0);
        read_line(10'h005);
        wait_idle("t2");
        chk_cnt("t2");
        chk("t2_err", {31'h0, proto_err_o}, 0);

        // 3: command during WAIT is flagged and ignored
        read_line(10'h005);
        @(negedge CLK);
        c2_i = 2'd2;
        a2_i = 10'h007;
        @(negedge CLK);
        c2_i = 2'd0;
        wait_idle("t3");
        chk("t3_err", {31'h0, proto_err_o}, 1);
        chk_cnt("t3");

        // 4: dropped command on beat 3 still commits the whole line
        do_reset();
        chk("t4_pre_err", {31'h0, proto_err_o}, 0);
        write_line(10'h007, mk_line(16'h0A01, 16'h0102), 3);
        wait_idle("t4w");
        chk("t4_err", {31'h0, proto_err_o}, 1);
        read_line(10'h007);
        wait_idle("t4r");
        chk_cnt("t4");

        // 5: reset mid-write leaves memory untouched
        write_line(10'h00A, mk_line(16'h5A00, 16'h0001), -1);
        wait_idle("t5a");
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            c2_i = 2'd3;
            a2_i = 10'h00A;
            d2_i = 16'hC300 + 16'(i);
        end
        @(negedge CLK);
        chk("t5_busy_pre", {31'h0, busy_o}, 1);
        c2_i = 2'd0;
        RESET = 1'b0;
        #1;
        chk("t5_c2", {30'h0, c2_o}, 0);
        chk("t5_busy", {31'h0, busy_o}, 0);
        chk("t5_err", {31'h0, proto_err_o}, 0);
        chk("t5_rd", {16'h0, rd_cnt_o}, 0);
        chk("t5_wr", {16'h0, wr_cnt_o}, 0);
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        exp_rd = 0;
        exp_wr = 0;
        read_line(10'h00A);
        wait_idle("t5r");
        chk_cnt("t5");

        // 6: counter saturation in the narrow build
        for (int k = 0; k < 4; k++) begin
            read_line(10'h005);
            wait_idle("t6");
            chk_cnt("t6");
        end

        // RESPONSE from the master while idle
        @(negedge CLK);
        c2_i = 2'd1;
        @(negedge CLK);
        c2_i = 2'd0;
        @(negedge CLK);
        chk("idle_resp_err", {31'h0, proto_err_o}, 1);
        chk("idle_resp_busy", {31'h0, busy_o}, 0);
        chk("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_line_model.md
Name: mem_line_model

Overview:
- Parametrised, synthesizable backing-memory agent for the bus-2 (cache↔memory) side of the cache subsystem. It replaces the ad-hoc byte array in the cache bench.
- Serves whole cache lines: READ_LINE and WRITE_LINE transactions, programmable response latency, multi-beat bursts, line address sampled from A2.
- Adds protocol-violation detection and transaction counters, so benches and future multi-level cache tops can check traffic.

Parameters:
- ADDR_W, 10, line-address width; capacity is 2^ADDR_W lines.
- DATA_W, 16, bus-2 data width per beat; must divide LINE_BYTES*8.
- LINE_BYTES, 16, bytes per cache line.
- LATENCY, 100, wait cycles between last command beat and first RESPONSE beat; must be >=1.
- BEATS, LINE_BYTES*8/DATA_W, derived (localparam); 8 at defaults.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- a2_i  in  ADDR_W  line address, sampled only in the command cycle.
- c2_i  in  2  command: 0 NOP, 1 RESPONSE (illegal from master), 2 READ_LINE, 3 WRITE_LINE.
- d2_i  in  DATA_W  write data beats.
- c2_o  out  2  NOP (0) or RESPONSE (1).
- d2_o  out  DATA_W  read data beats; 0 when c2_o is NOP.
- busy_o  out  1  high in every state except IDLE.
- proto_err_o  out  1  sticky protocol-violation flag.
- rd_cnt_o  out  16  completed reads, saturating.
- wr_cnt_o  out  16  completed writes, saturating.

Behaviour:
- Storage: 2^ADDR_W x LINE_BYTES*8 bits. Not cleared by reset; initial contents come from a preload or are undefined.
- Beat order: beat i carries line bits [i*DATA_W +: DATA_W], lowest byte first.
- Reset (RESET=0, async): state=IDLE, c2_o=0, d2_o=0, busy_o=0, proto_err_o=0, both counters 0. Any partial write buffer is discarded and memory is untouched. Takes effect mid-transaction with no response.
- States: IDLE, WR_COLLECT, WAIT, RD_SEND, WR_ACK.
- IDLE, READ_LINE sampled at edge t0: latch a2_i, go to WAIT with the counter loaded to LATENCY-1.
- IDLE, WRITE_LINE at edge t0: latch a2_i and d2_i as beat 0.
  - BEATS=1: commit line at t0, go to WAIT.
  - Otherwise: go to WR_COLLECT.
- IDLE, RESPONSE: set proto_err_o, stay in IDLE. NOP: stay in IDLE.
- WR_COLLECT: capture d2_i as beats 1..BEATS-1 on edges t0+1..t0+BEATS-1.
  - If c2_i != WRITE_LINE on any of these edges, set proto_err_o; the beat is still captured.
  - The full line is written to memory at edge t0+BEATS-1, then go to WAIT.
- WAIT: decrement the counter each edge. At 0, go to RD_SEND (read) or WR_ACK (write).
- Read timing: c2_o=RESPONSE and d2_o=beat 0 are visible after edge t0+LATENCY. Beat i is visible after edge t0+LATENCY+i. c2_o returns to NOP after edge t0+LATENCY+BEATS; at that edge, rd_cnt++ and state returns to IDLE.
- Write timing: c2_o=RESPONSE for exactly one cycle after edge t0+BEATS-1+LATENCY, with d2_o=0. At the next edge, wr_cnt++ and state returns to IDLE.
- Back-to-back: a new command may be sampled on the same edge that leaves RD_SEND/WR_ACK for IDLE? No. Commands are accepted only while in IDLE, so at least one IDLE cycle separates transactions.
- Busy violations: any non-NOP c2_i in WAIT, RD_SEND or WR_ACK sets proto_err_o and is otherwise ignored.
- Coherence: write data is committed before WR_ACK, so a following READ_LINE to the same address returns the new data.
- Counters saturate at 16'hFFFF. proto_err_o clears only on reset.

Test Plan (LATENCY=4, DATA_W=16, LINE_BYTES=16, BEATS=8):
1. Reset, then WRITE_LINE a2=0x005 with beats 0x1111..0x8888 over 8 cycles -> one RESPONSE cycle 11 edges after the command edge; wr_cnt_o=1; proto_err_o=0.
2. READ_LINE a2=0x005 -> RESPONSE after edge t0+4 for 8 consecutive cycles, d2_o=0x1111,0x2222,…,0x8888; NOP after t0+12; rd_cnt_o=1.
3. Issue READ_LINE during the WAIT of a prior read -> proto_err_o=1; the prior read completes unchanged; rd_cnt_o increments by exactly 1.
4. WRITE_LINE with c2_i dropped to NOP on beat 3 -> proto_err_o=1; full line still committed; readback matches all 8 beats.
5. Pull RESET low after beat 5 of a WRITE_LINE to a2=0x00A (prior contents X) -> c2_o=0, busy_o=0, counters=0; later READ_LINE 0x00A returns X unchanged.
6. Force rd_cnt_o to 16'hFFFE via repeated reads (or a shortened-width build) -> after two more reads it holds at 16'hFFFF.
